// File: rtl/servo_pkg.sv
// Shared constants, duty-mapping helpers and frame FSM states for the servo command path.
package servo_pkg;

  localparam logic [7:0]  HDR_BYTE = 8'hFF;
  localparam int unsigned POS_MAX  = 250;

  typedef enum logic [1:0] {
    WAIT_HDR = 2'd0,
    WAIT_POS = 2'd1,
    WAIT_CHK = 2'd2
  } frame_state_t;

  // 1 ms and 2 ms high-time for a 20 ms PWM period
  function automatic int unsigned min_duty(input int unsigned period);
    return period / 20;
  endfunction

  function automatic int unsigned max_duty(input int unsigned period);
    return period / 10;
  endfunction

  function automatic int unsigned duty_step(input int unsigned period);
    return (max_duty(period) - min_duty(period)) / POS_MAX;
  endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, one-cycle byte/stop-error pulses.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       stop_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  rx_state_t     state, state_next;
  logic          sync1, rx_s, rx_d;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          fall, start_tick, bit_tick;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      sync1 <= uart_rx;
      rx_s  <= sync1;
      rx_d  <= rx_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RX_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    fall       = rx_d & ~rx_s;
    start_tick = (state == RX_START) && (cnt == HALF_LAST);
    bit_tick   = ((state == RX_DATA) || (state == RX_STOP)) && (cnt == BIT_LAST);
  end

  always_comb begin
    state_next = state;
    case (state)
      RX_IDLE:  if (fall) state_next = RX_START;
      // a start bit that is high again at mid-bit was a glitch
      RX_START: if (start_tick) state_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (bit_tick && (bit_idx == 3'd7)) state_next = RX_STOP;
      RX_STOP:  if (bit_tick) state_next = RX_IDLE;
      default:  state_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_data  <= '0;
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
      if ((state == RX_IDLE) || start_tick || bit_tick) cnt <= '0;
      else                                             cnt <= cnt + 1'b1;
      if (start_tick) bit_idx <= '0;
      if (bit_tick && (state == RX_DATA)) begin
        shreg   <= {rx_s, shreg[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
      if (bit_tick && (state == RX_STOP)) begin
        byte_data  <= shreg;
        byte_valid <= rx_s;
        stop_err   <= ~rx_s;
      end
    end
  end

endmodule

// File: rtl/servo_cmd_rx.sv
// Validates FF/P/~P position frames from the UART and drives the servo PWM high-time.
module servo_cmd_rx
  import servo_pkg::*;
#(
  parameter int unsigned CLK_FREQ       = 25_000_000,
  parameter int unsigned BAUD           = 115_200,
  parameter int unsigned PERIOD         = 500_000,
  parameter int unsigned TIMEOUT_CYCLES = 250_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic [31:0] duty_cycle,
  output logic        cmd_valid,
  output logic        frame_err
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned MIN_DUTY     = min_duty(PERIOD);
  localparam int unsigned STEP         = duty_step(PERIOD);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic         byte_valid, stop_err;
  logic [7:0]   byte_data;
  frame_state_t state, state_next;
  logic [TW-1:0] gap;
  logic [7:0]   pos_q;
  logic         timeout, load_c, err_c, pos_ld;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .rst        (rst),
    .uart_rx    (uart_rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .stop_err   (stop_err)
  );

  assign timeout = (state != WAIT_HDR) && (gap == GAP_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= WAIT_HDR;
    else     state <= state_next;
  end

  // framing errors and timeouts override the byte-driven transitions
  always_comb begin
    state_next = state;
    if (stop_err || timeout) begin
      state_next = WAIT_HDR;
    end else if (byte_valid) begin
      case (state)
        WAIT_HDR: if (byte_data == HDR_BYTE) state_next = WAIT_POS;
        WAIT_POS: begin
          if (byte_data == HDR_BYTE)             state_next = WAIT_POS;
          else if (32'(byte_data) <= POS_MAX)    state_next = WAIT_CHK;
          else                                   state_next = WAIT_HDR;
        end
        WAIT_CHK: state_next = WAIT_HDR;
        default:  state_next = WAIT_HDR;
      endcase
    end
  end

  always_comb begin
    load_c = 1'b0;
    err_c  = 1'b0;
    pos_ld = 1'b0;
    if (stop_err || timeout) begin
      err_c = 1'b1;
    end else if (byte_valid) begin
      case (state)
        WAIT_POS: begin
          if (byte_data != HDR_BYTE) begin
            if (32'(byte_data) <= POS_MAX) pos_ld = 1'b1;
            else                           err_c  = 1'b1;
          end
        end
        WAIT_CHK: begin
          if (byte_data == ~pos_q) load_c = 1'b1;
          else                     err_c  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap        <= '0;
      pos_q      <= '0;
      duty_cycle <= 32'(MIN_DUTY);
      cmd_valid  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if ((state == WAIT_HDR) || byte_valid || stop_err) gap <= '0;
      else                                               gap <= gap + 1'b1;
      if (pos_ld) pos_q <= byte_data;
      if (load_c) duty_cycle <= 32'(MIN_DUTY) + 32'(pos_q) * 32'(STEP);
      cmd_valid <= load_c;
      frame_err <= err_c;
    end
  end

endmodule

// File: tb/tb_servo_cmd_rx.sv
// Directed frame sequences with an expected-duty queue checked on every cmd_valid pulse.
module tb_servo_cmd_rx;

  // Faster baud and shorter timeout keep the run short; duty math uses the real PERIOD.
  localparam int unsigned CLK_FREQ = 1_600_000;
  localparam int unsigned BAUD     = 100_000;
  localparam int unsigned CPB      = CLK_FREQ / BAUD;
  localparam int unsigned PERIOD   = 500_000;
  localparam int unsigned TIMEOUT  = 2_000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_rx = 1'b1;
  logic [31:0] duty_cycle;
  logic        cmd_valid;
  logic        frame_err;

  int passed = 0;
  int total = 0;
  int cv_seen = 0;
  int fe_seen = 0;
  logic [31:0] exp_q[$];

  servo_cmd_rx #(
    .CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .PERIOD(PERIOD), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_rx    (uart_rx),
    .duty_cycle (duty_cycle),
    .cmd_valid  (cmd_valid),
    .frame_err  (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      wait_clks(CPB);
    end
    uart_rx = stop_bit;
    wait_clks(CPB);
    uart_rx = 1'b1;
    if (!stop_bit) wait_clks(CPB);
    wait_clks(2);
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    send_byte(b0, 1'b1);
    send_byte(b1, 1'b1);
    send_byte(b2, 1'b1);
  endtask

  task automatic step_begin();
    cv_seen = 0;
    fe_seen = 0;
  endtask

  task automatic step_end(input string tag, input int exp_cv, input int exp_fe,
                          input logic [31:0] exp_duty);
    wait_clks(4 * CPB);
    @(negedge clk);
    check({tag, "_cmd_valid_count"}, 32'(cv_seen), 32'(exp_cv));
    check({tag, "_frame_err_count"}, 32'(fe_seen), 32'(exp_fe));
    check({tag, "_duty"}, duty_cycle, exp_duty);
    check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    wait_clks(20);
  endtask

  // scoreboard: every cmd_valid must match the oldest expected duty
  always @(negedge clk) begin
    if (!rst && (cmd_valid || frame_err)) begin
      check("pulse_exclusive", 32'(cmd_valid & frame_err), 32'd0);
      if (frame_err) fe_seen++;
      if (cmd_valid) begin
        cv_seen++;
        check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("sb_duty", duty_cycle, exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1;
    wait_clks(5);
    @(negedge clk);
    check("in_reset_duty", duty_cycle, 32'd25_000);
    rst = 1'b0;
    wait_clks(3);
    @(negedge clk);
    check("reset_duty", duty_cycle, 32'd25_000);
    check("reset_cmd_valid", 32'(cmd_valid), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    wait_clks(50);

    step_begin();
    exp_q.push_back(32'd37_500);
    send_frame(8'hFF, 8'h7D, 8'h82);
    step_end("mid_pos", 1, 0, 32'd37_500);

    step_begin();
    exp_q.push_back(32'd50_000);
    send_frame(8'hFF, 8'hFA, 8'h05);
    step_end("max_pos", 1, 0, 32'd50_000);

    step_begin();
    send_frame(8'hFF, 8'h64, 8'h00);
    step_end("bad_check", 0, 1, 32'd50_000);

    step_begin();
    exp_q.push_back(32'd25_000);
    send_byte(8'hFF, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    step_end("resync_min", 1, 0, 32'd25_000);

    step_begin();
    send_frame(8'hFF, 8'hFB, 8'h04);
    step_end("out_of_range", 0, 1, 32'd25_000);

    step_begin();
    send_byte(8'hFF, 1'b1);
    send_byte(8'h7D, 1'b1);
    wait_clks(TIMEOUT + TIMEOUT / 10 * 3);
    @(negedge clk);
    check("timeout_err_before_late_byte", 32'(fe_seen), 32'd1);
    send_byte(8'h82, 1'b1);
    step_end("timeout", 0, 1, 32'd25_000);

    step_begin();
    send_byte(8'hFF, 1'b0);
    send_byte(8'h7D, 1'b1);
    send_byte(8'h82, 1'b1);
    step_end("stop_bit_err", 0, 1, 32'd25_000);

    step_begin();
    exp_q.push_back(32'd37_500);
    send_frame(8'hFF, 8'h7D, 8'h82);
    step_end("pre_reset_load", 1, 0, 32'd37_500);

    step_begin();
    send_byte(8'hFF, 1'b1);
    rst = 1'b1;
    wait_clks(3);
    @(negedge clk);
    check("mid_frame_reset_duty", duty_cycle, 32'd25_000);
    rst = 1'b0;
    wait_clks(5);
    send_byte(8'h7D, 1'b1);
    send_byte(8'h82, 1'b1);
    step_end("after_reset", 0, 0, 32'd25_000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/servo_cmd_rx.md
# servo_cmd_rx

Upstream command stage for the servo path: receives 8N1 UART frames from the remote controller, validates a 3-byte position command and converts it to a PWM high-time in clock cycles. Its `duty_cycle` output drives the servo PWM stage directly, in place of the free-running toggle. Bad or incomplete frames never disturb the current servo position.

## Interface
- `CLK_FREQ`, 25_000_000: system clock in Hz.
- `BAUD`, 115_200: UART bit rate. `CLKS_PER_BIT = CLK_FREQ/BAUD` (217 at defaults).
- `PERIOD`, 500_000: PWM period in cycles (20 ms). `MIN_DUTY = PERIOD/20`, `MAX_DUTY = PERIOD/10`.
- `TIMEOUT_CYCLES`, 250_000: maximum idle gap between bytes of one frame (10 ms).
- `clk`  in  1  system clock. One clock domain.
- `rst`  in  1  asynchronous, active-high reset.
- `uart_rx`  in  1  asynchronous serial input, idles high.
- `duty_cycle`  out  32  PWM high-time in cycles. Reset value `MIN_DUTY` (25_000).
- `cmd_valid`  out  1  one-cycle pulse when `duty_cycle` takes a new value. Reset value 0.
- `frame_err`  out  1  one-cycle pulse on any rejected byte or frame. Reset value 0.

## Operation
- Frame format: header `0xFF`, then position `P` (0..250), then check byte `C` = ~P (bitwise inverse).
- Mapping: `duty_cycle = MIN_DUTY + P*STEP`, where `STEP = (MAX_DUTY-MIN_DUTY)/250` (100 at defaults). Compute the product in 32 bits; no division in hardware.
- Frame FSM states are `WAIT_HDR`, `WAIT_POS` and `WAIT_CHK`.
  - `WAIT_HDR`: `0xFF` moves to `WAIT_POS`. Any other byte is silently ignored, with no `frame_err`.
  - `WAIT_POS`: `0xFF` is treated as a fresh header and stays in `WAIT_POS`, with no error. `P` ≤ 250 is latched and moves to `WAIT_CHK`. `P` in 251..254 pulses `frame_err` and returns to `WAIT_HDR`.
  - `WAIT_CHK`: `C == ~P` loads `duty_cycle`, pulses `cmd_valid` and returns to `WAIT_HDR`. Any other value pulses `frame_err` and returns to `WAIT_HDR`.
- Timeout: a gap counter runs only in `WAIT_POS` and `WAIT_CHK`, and clears on each received byte. When it reaches `TIMEOUT_CYCLES`, return to `WAIT_HDR` and pulse `frame_err`.
- UART framing error (stop bit sampled low): drop the byte, pulse `frame_err`, and force `WAIT_HDR` regardless of the current state.
- Reset, including reset mid-frame: FSM goes to `WAIT_HDR`, all counters clear, outputs take their reset values. The receiver restarts hunting for a start bit.

## Timing
- `uart_rx` passes through a 2-flop synchronizer before any use.
- Start detection: a synchronized falling edge starts the bit counter. The start bit is re-sampled at `CLKS_PER_BIT/2`; if it is high there, it is a glitch and the receiver returns to idle with no byte and no error.
- Data bits are sampled LSB first, every `CLKS_PER_BIT` after the start mid-point. The stop bit is sampled one `CLKS_PER_BIT` after data bit 7.
- The receiver raises a `byte_valid` pulse in the cycle after the stop-bit mid-sample.
- The FSM consumes a byte in the cycle `byte_valid` is high. `duty_cycle`, `cmd_valid` and `frame_err` are registered one cycle later.
- A new start bit is accepted immediately after the stop-bit mid-sample, so back-to-back bytes are supported.
- `cmd_valid` and `frame_err` are never high in the same cycle.

## Structure
- Shared package `servo_pkg` holds `MIN_DUTY`/`MAX_DUTY` derivation, `HDR_BYTE = 8'hFF`, `POS_MAX = 250`, `STEP`, and the FSM state enum.
- Sub-module `uart_rx`: synchronizer, baud counter, shift register. Outputs are `byte_valid`, `byte_data[7:0]` and `stop_err`.
- `servo_cmd_rx` holds the frame FSM, timeout counter and duty register only.

## Test plan
- Reset: hold `rst` high, then release → `duty_cycle` = 25_000, `cmd_valid` = 0, `frame_err` = 0.
- Send `FF 7D 82` → `duty_cycle` = 37_500, exactly one `cmd_valid` pulse, no `frame_err`. Then send `FF FA 05` → `duty_cycle` = 50_000.
- Send `FF 64 00` (bad check byte) → one `frame_err` pulse, `duty_cycle` unchanged. Then send `FF FF 00 FF` → `duty_cycle` = 25_000 and no error, because the repeated header resynchronizes.
- Send `FF FB 04` (out of range) → `frame_err` pulses on the `FB` byte; the following `04` is ignored in `WAIT_HDR`; `duty_cycle` unchanged.
- Send `FF 7D`, idle for 260_000 cycles, then send `82` → one `frame_err` at timeout, no `cmd_valid`, `duty_cycle` unchanged.
- Send `FF` with its stop bit forced low, then `7D 82` → `frame_err` pulse and no update. Also assert `rst` between `FF` and `7D` of a valid frame → no update, and `duty_cycle` = 25_000.
